// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller sequencing one accumulator-class op through the shared ALU.
// Define ALU_SEQ_FADD_EN to enable the FADD (opcode 100) path; otherwise opcode 100 is illegal.
module alu_op_sequencer #(
  parameter int unsigned FADD_LAT    = 2,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] opcode,
  output logic       ready,
  output logic       busy,
  output logic       mem_rd,
  input  logic       mem_ack,
  output logic       dr_ld,
  input  logic       fgi,
  output logic       fgi_clr,
  output logic [1:0] alu_sel,
  output logic       alu_float,
  output logic       ac_ld,
  output logic       e_ld,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_LDA  = 3'b010;
  localparam logic [2:0] OP_INP  = 3'b011;
  localparam logic [2:0] OP_FADD = 3'b100;

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
`ifdef ALU_SEQ_FADD_EN
  localparam logic [CNT_W-1:0] FADD_LAST = CNT_W'(FADD_LAT - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
`ifdef ALU_SEQ_FADD_EN
    S_EXEC,
`endif
    S_INWAIT,
    S_WB,
    S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       sel_q, sel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (opcode)
            OP_AND, OP_ADD, OP_LDA: state_d = S_FETCH;
            OP_INP:                 state_d = S_INWAIT;
`ifdef ALU_SEQ_FADD_EN
            OP_FADD:                state_d = S_FETCH;
`endif
            default:                state_d = S_ERR;
          endcase
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
`ifdef ALU_SEQ_FADD_EN
          state_d = (op_q == OP_FADD) ? S_EXEC : S_WB;
`else
          state_d = S_WB;
`endif
        end else if (MEM_TIMEOUT != 0 && cnt_q == TO_LAST) begin
          state_d = S_ERR;
        end
      end
`ifdef ALU_SEQ_FADD_EN
      S_EXEC:   if (cnt_q == FADD_LAST) state_d = S_WB;
`endif
      S_INWAIT: if (fgi) state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Counter restarts on every state change; it only advances in the timed states.
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    sel_d = sel_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == S_FETCH
`ifdef ALU_SEQ_FADD_EN
                 || state_q == S_EXEC
`endif
                ) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (state_q == S_IDLE && start) begin
      op_d = opcode;
      unique case (opcode)
        OP_ADD:  sel_d = 2'b01;
        OP_LDA:  sel_d = 2'b10;
        OP_INP:  sel_d = 2'b11;
`ifdef ALU_SEQ_FADD_EN
        OP_FADD: sel_d = 2'b01;
`endif
        default: sel_d = 2'b00;
      endcase
    end else if (state_q == S_WB || state_q == S_ERR) begin
      sel_d = '0;
    end
  end

  always_comb begin
    ready     = (state_q == S_IDLE);
    busy      = ~ready;
    mem_rd    = (state_q == S_FETCH);
    dr_ld     = (state_q == S_FETCH) && mem_ack;
    alu_sel   = sel_q;
    ac_ld     = (state_q == S_WB);
    done      = (state_q == S_WB);
    e_ld      = (state_q == S_WB) && (op_q == OP_ADD || op_q == OP_FADD);
    fgi_clr   = (state_q == S_WB) && (op_q == OP_INP);
    err       = (state_q == S_ERR);
`ifdef ALU_SEQ_FADD_EN
    alu_float = (state_q == S_EXEC) || (state_q == S_WB && op_q == OP_FADD);
`else
    alu_float = 1'b0;
`endif
  end

endmodule
